cond_unit: RTL

- Execute-stage condition unit of the pipelined ARM-subset core.
- Captures decode control into the D→E pipeline register and holds the architectural NZCV flags register.
- Evaluates the instruction condition with the existing ConditionCheck module and gates register, memory and PC side effects.
- Counts annulled instructions for performance monitoring.

---
 rtl/core_pkg.sv | 32 +++
 rtl/cond_unit_condition_check.sv | 39 +++
 rtl/cond_unit.sv | 92 +++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types for the ARM-subset core: condition codes, NZCV bit positions
// and the decode-to-execute control bundle.
package core_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  localparam int unsigned N = 3;
  localparam int unsigned Z = 2;
  localparam int unsigned C = 1;
  localparam int unsigned V = 0;

  typedef struct packed {
    logic        valid;
    cond_e       cond;
    logic [1:0]  flag_w;
    logic        reg_w;
    logic        mem_w;
    logic        pc_s;
    logic        no_write;
  } ctrl_de_t;

  localparam ctrl_de_t CTRL_BUBBLE = '{
    valid: 1'b0, cond: AL, flag_w: 2'b00,
    reg_w: 1'b0, mem_w: 1'b0, pc_s: 1'b0, no_write: 1'b0
  };

endpackage

// File: rtl/cond_unit_condition_check.sv
// ConditionCheck: evaluates an ARM condition field against NZCV.
// NV (1111) yields 0; callers handle it as an illegal encoding.
module ConditionCheck
  import core_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  always_comb begin
    n = flags[N];
    z = flags[Z];
    c = flags[C];
    v = flags[V];
    cond_ex = 1'b0;
    case (cond)
      EQ:      cond_ex = z;
      NE:      cond_ex = ~z;
      CS:      cond_ex = c;
      CC:      cond_ex = ~c;
      MI:      cond_ex = n;
      PL:      cond_ex = ~n;
      VS:      cond_ex = v;
      VC:      cond_ex = ~v;
      HI:      cond_ex = c & ~z;
      LS:      cond_ex = ~c | z;
      GE:      cond_ex = (n == v);
      LT:      cond_ex = (n != v);
      GT:      cond_ex = ~z & (n == v);
      LE:      cond_ex = z | (n != v);
      AL:      cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: D->E control register, NZCV flags register,
// condition-qualified side effects and a saturating annulled-instruction counter.
module cond_unit
  import core_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_valid,
  input  logic [3:0]       d_cond,
  input  logic [1:0]       d_flag_w,
  input  logic             d_reg_w,
  input  logic             d_mem_w,
  input  logic             d_pc_s,
  input  logic             d_no_write,
  input  logic             stall_e,
  input  logic             flush_e,
  input  logic [3:0]       alu_flags,
  input  logic             cnt_clr,
  output logic             e_valid,
  output logic             cond_ex_e,
  output logic             reg_write_e,
  output logic             mem_write_e,
  output logic             pc_src_e,
  output logic [3:0]       flags_q,
  output logic             illegal_cond,
  output logic [CNT_W-1:0] annul_cnt
);

  ctrl_de_t de_q;
  logic     cc_pass;
  logic     commit;
  logic     annul;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q <= CTRL_BUBBLE;
    end else if (flush_e) begin
      de_q <= CTRL_BUBBLE;
    end else if (!stall_e) begin
      de_q <= '{
        valid:    d_valid,
        cond:     cond_e'(d_cond),
        flag_w:   d_flag_w,
        reg_w:    d_reg_w,
        mem_w:    d_mem_w,
        pc_s:     d_pc_s,
        no_write: d_no_write
      };
    end
  end

  ConditionCheck u_condition_check (
    .cond    (de_q.cond),
    .flags   (flags_q),
    .cond_ex (cc_pass)
  );

  always_comb begin
    e_valid      = de_q.valid;
    illegal_cond = de_q.valid & (de_q.cond == NV);
    cond_ex_e    = de_q.valid & cc_pass & (de_q.cond != NV);
    commit       = e_valid & cond_ex_e & ~stall_e;
    annul        = e_valid & ~cond_ex_e & ~stall_e;
    reg_write_e  = commit & de_q.reg_w & ~de_q.no_write;
    mem_write_e  = commit & de_q.mem_w;
    pc_src_e     = commit & de_q.pc_s;
  end

  // Flags update at the end of the commit cycle, so the next instruction
  // sees them without any bypass path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (commit) begin
      if (de_q.flag_w[1]) flags_q[N:Z] <= alu_flags[N:Z];
      if (de_q.flag_w[0]) flags_q[C:V] <= alu_flags[C:V];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      annul_cnt <= '0;
    end else if (cnt_clr) begin
      annul_cnt <= '0;
    end else if (annul && (annul_cnt != '1)) begin
      annul_cnt <= annul_cnt + 1'b1;
    end
  end

endmodule
